// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port data memory between the processor load/store path
//   and a DMA requester. Each access occupies the memory for LAT cycles and is
//   followed by one IDLE turnaround cycle. When both sides ask at once, the one
//   that was not served last wins, so neither side can starve. The processor is
//   frozen (cpu_enable low) while its own request is waiting or in flight, and
//   it advances in exactly the cycle its access completes.
//
// Parameters
//   AW  : address width
//   DW  : data width
//   LAT : memory cycles per transaction (>= 1)
//
// Ports
//   clk, rst_n          : clock; synchronous active-low reset
//   cpu_req/we/addr/wdata : processor load/store request
//   cpu_rdata           : load data, valid in the CPU completion cycle only
//   cpu_enable          : processor advance enable (controller enable input)
//   dma_req/we/addr/wdata : DMA request, held until dma_done
//   dma_gnt             : DMA owns the memory this cycle
//   dma_done, dma_rdata : one-cycle completion pulse and its read data
//   mem_addr/we/wdata   : memory port; mem_rdata is combinational from mem_addr
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_enable,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic grant_s;
  logic pick_dma_s;
  logic access_s;
  logic final_s;

  // Next-state logic: arbitration in IDLE, countdown in ACCESS.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    grant_s    = 1'b0;
    pick_dma_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && dma_req) begin
          // Tie: serve whoever was not served last.
          grant_s    = 1'b1;
          pick_dma_s = (last_gnt_q == OWN_CPU);
        end else if (cpu_req) begin
          grant_s    = 1'b1;
          pick_dma_s = OWN_CPU;
        end else if (dma_req) begin
          grant_s    = 1'b1;
          pick_dma_s = OWN_DMA;
        end else begin
          grant_s    = 1'b0;
          pick_dma_s = OWN_CPU;
        end
        if (grant_s) begin
          state_d    = ACCESS;
          owner_d    = pick_dma_s;
          last_gnt_d = pick_dma_s;
          cnt_d      = CNT_LOAD;
          if (pick_dma_s) begin
            addr_d  = dma_addr;
            we_d    = dma_we;
            wdata_d = dma_wdata;
          end else begin
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // A withdrawn request does not abort: the access always runs to cnt == 0.
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; last_gnt resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      last_gnt_q <= OWN_DMA;
      cnt_q      <= CNT_ZERO;
      addr_q     <= {AW{1'b0}};
      we_q       <= 1'b0;
      wdata_q    <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  assign access_s = (state_q == ACCESS);
  assign final_s  = access_s && (cnt_q == CNT_ZERO);

  // Memory port: driven only while an access is in progress; one strobe per store.
  assign mem_addr  = access_s ? addr_q  : {AW{1'b0}};
  assign mem_wdata = access_s ? wdata_q : {DW{1'b0}};
  assign mem_we    = final_s && we_q;

  // Completion signalling to the two requesters.
  assign cpu_rdata  = (final_s && (owner_q == OWN_CPU)) ? mem_rdata : {DW{1'b0}};
  assign dma_done   = final_s && (owner_q == OWN_DMA);
  assign dma_rdata  = dma_done ? mem_rdata : {DW{1'b0}};
  assign dma_gnt    = access_s && (owner_q == OWN_DMA);

  // The processor runs unless it needs memory, and then only in its completion cycle.
  assign cpu_enable = !cpu_req || (final_s && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. u2 runs with LAT = 2, u1 with LAT = 1.
//   The memory is modelled as a fixed function of the address, so every
//   expected read value below is a hand-computed constant:
//     rdata(a) = {a[15:0] ^ a[31:16], ~a[15:0]}
//     0x10 -> 0x0010FFEF, 0x20 -> 0x0020FFDF, 0x30 -> 0x0030FFCF
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;

  // LAT = 2 instance
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_enable, dma_gnt, dma_done, mem_we;

  // LAT = 1 instance
  logic        cpu_req1, cpu_we1, dma_req1, dma_we1;
  logic [31:0] cpu_addr1, cpu_wdata1, dma_addr1, dma_wdata1;
  logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        cpu_enable1, dma_gnt1, dma_done1, mem_we1;

  int vectors;
  int miscompares;

  logic [11:0] rr_gnt;
  logic [11:0] rr_en;
  logic [11:0] rr_done;

  mem_arbiter #(.AW(32), .DW(32), .LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
    .cpu_rdata(cpu_rdata1), .cpu_enable(cpu_enable1),
    .dma_req(dma_req1), .dma_we(dma_we1), .dma_addr(dma_addr1), .dma_wdata(dma_wdata1),
    .dma_gnt(dma_gnt1), .dma_done(dma_done1), .dma_rdata(dma_rdata1),
    .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  assign mem_rdata  = {mem_addr[15:0]  ^ mem_addr[31:16],  ~mem_addr[15:0]};
  assign mem_rdata1 = {mem_addr1[15:0] ^ mem_addr1[31:16], ~mem_addr1[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge (input-drive point).
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    cpu_req1 = 1'b0; cpu_we1 = 1'b0; cpu_addr1 = 32'h0; cpu_wdata1 = 32'h0;
    dma_req1 = 1'b0; dma_we1 = 1'b0; dma_addr1 = 32'h0; dma_wdata1 = 32'h0;

    // ---- Reset held 2 cycles with cpu_req = 1 ----
    cpu_req = 1'b1; cpu_addr = 32'h10;
    tick(); tick(); #1;
    chk1 ("rst_mem_we",     mem_we,     1'b0);
    chk1 ("rst_dma_gnt",    dma_gnt,    1'b0);
    chk1 ("rst_dma_done",   dma_done,   1'b0);
    chk1 ("rst_cpu_enable", cpu_enable, 1'b0);
    chk32("rst_mem_addr",   mem_addr,   32'h0);
    chk32("rst_mem_wdata",  mem_wdata,  32'h0);
    chk32("rst_cpu_rdata",  cpu_rdata,  32'h0);
    chk32("rst_dma_rdata",  dma_rdata,  32'h0);
    chk1 ("rst1_dma_gnt",   dma_gnt1,   1'b0);
    chk1 ("rst1_dma_done",  dma_done1,  1'b0);
    chk32("rst1_dma_rdata", dma_rdata1, 32'h0);
    chk32("rst1_mem_wdata", mem_wdata1, 32'h0);
    chk1 ("rst1_cpu_enable", cpu_enable1, 1'b1);

    // Release: CPU granted at the next edge, enabled two cycles later.
    rst_n = 1'b1; #1;
    chk1 ("rel_c0_enable", cpu_enable, 1'b0);
    tick(); #1;
    chk1 ("rel_c1_enable", cpu_enable, 1'b0);
    chk32("rel_c1_addr",   mem_addr,   32'h10);
    tick(); #1;
    chk1 ("rel_c2_enable", cpu_enable, 1'b1);
    chk32("rel_c2_rdata",  cpu_rdata,  32'h0010FFEF);
    chk1 ("rel_c2_we",     mem_we,     1'b0);
    tick(); cpu_req = 1'b0; #1;
    chk1 ("rel_c3_enable", cpu_enable, 1'b1);
    chk32("rel_c3_addr",   mem_addr,   32'h0);

    // ---- CPU store alone ----
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; #1;
    chk1 ("st_c0_enable", cpu_enable, 1'b0);
    chk1 ("st_c0_we",     mem_we,     1'b0);
    tick(); #1;
    chk1 ("st_c1_enable", cpu_enable, 1'b0);
    chk1 ("st_c1_we",     mem_we,     1'b0);
    chk32("st_c1_addr",   mem_addr,   32'h40);
    chk32("st_c1_wdata",  mem_wdata,  32'hDEADBEEF);
    tick(); #1;
    chk1 ("st_c2_enable", cpu_enable, 1'b1);
    chk1 ("st_c2_we",     mem_we,     1'b1);
    chk32("st_c2_addr",   mem_addr,   32'h40);
    chk32("st_c2_wdata",  mem_wdata,  32'hDEADBEEF);
    tick(); cpu_req = 1'b0; cpu_we = 1'b0; #1;
    chk1 ("st_c3_we",     mem_we,     1'b0);
    chk32("st_c3_wdata",  mem_wdata,  32'h0);

    // ---- Simultaneous requests after a fresh reset: CPU first, then DMA ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; #1;
    chk1 ("sim_c0_enable", cpu_enable, 1'b0);
    tick(); #1;
    chk1 ("sim_c1_enable", cpu_enable, 1'b0);
    chk1 ("sim_c1_gnt",    dma_gnt,    1'b0);
    chk32("sim_c1_addr",   mem_addr,   32'h10);
    tick(); #1;
    chk1 ("sim_c2_enable", cpu_enable, 1'b1);
    chk32("sim_c2_rdata",  cpu_rdata,  32'h0010FFEF);
    chk1 ("sim_c2_done",   dma_done,   1'b0);
    tick(); cpu_req = 1'b0; #1;
    chk1 ("sim_c3_gnt",    dma_gnt,    1'b0);
    chk32("sim_c3_addr",   mem_addr,   32'h0);
    tick(); #1;
    chk1 ("sim_c4_gnt",    dma_gnt,    1'b1);
    chk1 ("sim_c4_done",   dma_done,   1'b0);
    chk32("sim_c4_addr",   mem_addr,   32'h20);
    chk32("sim_c4_rdata",  dma_rdata,  32'h0);
    tick(); #1;
    chk1 ("sim_c5_gnt",    dma_gnt,    1'b1);
    chk1 ("sim_c5_done",   dma_done,   1'b1);
    chk32("sim_c5_rdata",  dma_rdata,  32'h0020FFDF);
    chk32("sim_c5_cpu_rdata", cpu_rdata, 32'h0);
    tick(); dma_req = 1'b0; #1;
    chk1 ("sim_c6_gnt",    dma_gnt,    1'b0);
    chk1 ("sim_c6_done",   dma_done,   1'b0);

    // ---- Round-robin: both held 12 cycles, last grant was DMA ----
    // cycle:  c0 IDLE, c1-2 CPU, c3 IDLE, c4-5 DMA, c6 IDLE, c7-8 CPU, c9 IDLE, c10-11 DMA
    rr_gnt  = 12'b1100_0011_0000;
    rr_en   = 12'b0001_0000_0100;
    rr_done = 12'b1000_0010_0000;
    cpu_req = 1'b1; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_addr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk1($sformatf("rr_c%0d_gnt", i),    dma_gnt,    rr_gnt[i]);
      chk1($sformatf("rr_c%0d_enable", i), cpu_enable, rr_en[i]);
      chk1($sformatf("rr_c%0d_done", i),   dma_done,   rr_done[i]);
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0; #1;
    chk1 ("rr_c12_gnt", dma_gnt, 1'b0);

    // ---- DMA write with the CPU idle ----
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h12345678; #1;
    chk1 ("dw_d0_enable", cpu_enable, 1'b1);
    tick(); #1;
    chk1 ("dw_d1_enable", cpu_enable, 1'b1);
    chk1 ("dw_d1_gnt",    dma_gnt,    1'b1);
    chk1 ("dw_d1_we",     mem_we,     1'b0);
    chk32("dw_d1_addr",   mem_addr,   32'h80);
    tick(); #1;
    chk1 ("dw_d2_enable", cpu_enable, 1'b1);
    chk1 ("dw_d2_we",     mem_we,     1'b1);
    chk32("dw_d2_wdata",  mem_wdata,  32'h12345678);
    chk1 ("dw_d2_done",   dma_done,   1'b1);
    tick(); dma_req = 1'b0; dma_we = 1'b0; #1;
    chk1 ("dw_d3_we",     mem_we,     1'b0);

    // ---- CPU raised during a DMA read: frozen until its own completion ----
    dma_req = 1'b1; dma_addr = 32'h20;
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h10; #1;
    chk1 ("mid_d5_enable", cpu_enable, 1'b0);
    chk1 ("mid_d5_gnt",    dma_gnt,    1'b1);
    tick(); #1;
    chk1 ("mid_d6_enable", cpu_enable, 1'b0);
    chk1 ("mid_d6_done",   dma_done,   1'b1);
    tick(); dma_req = 1'b0; #1;
    chk1 ("mid_d7_enable", cpu_enable, 1'b0);
    tick(); #1;
    chk1 ("mid_d8_enable", cpu_enable, 1'b0);
    chk32("mid_d8_addr",   mem_addr,   32'h10);
    tick(); #1;
    chk1 ("mid_d9_enable", cpu_enable, 1'b1);
    chk32("mid_d9_rdata",  cpu_rdata,  32'h0010FFEF);
    tick(); cpu_req = 1'b0; #1;

    // ---- Reset in the middle of a DMA write ----
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'hCAFEF00D;
    tick(); #1;
    chk1 ("rma_gnt", dma_gnt, 1'b1);
    chk1 ("rma_we",  mem_we,  1'b0);
    rst_n = 1'b0;
    tick(); #1;
    chk1 ("rma_e1_we",   mem_we,   1'b0);
    chk1 ("rma_e1_done", dma_done, 1'b0);
    chk1 ("rma_e1_gnt",  dma_gnt,  1'b0);
    chk32("rma_e1_addr", mem_addr, 32'h0);
    rst_n = 1'b1; dma_req = 1'b0; dma_we = 1'b0;
    tick(); #1;
    chk1 ("rma_e2_we",   mem_we,   1'b0);
    chk1 ("rma_e2_done", dma_done, 1'b0);

    // ---- LAT = 1: completion the cycle after the request, then every 2 cycles ----
    cpu_req1 = 1'b1; cpu_addr1 = 32'h10; #1;
    chk1 ("l1_e0_enable", cpu_enable1, 1'b0);
    tick(); cpu_addr1 = 32'h30; #1;
    chk1 ("l1_e1_enable", cpu_enable1, 1'b1);
    chk32("l1_e1_rdata",  cpu_rdata1,  32'h0010FFEF);
    tick(); #1;
    chk1 ("l1_e2_enable", cpu_enable1, 1'b0);
    chk32("l1_e2_rdata",  cpu_rdata1,  32'h0);
    tick(); #1;
    chk1 ("l1_e3_enable", cpu_enable1, 1'b1);
    chk32("l1_e3_rdata",  cpu_rdata1,  32'h0030FFCF);
    tick();
    cpu_we1 = 1'b1; cpu_addr1 = 32'h44; cpu_wdata1 = 32'h000055AA; #1;
    chk1 ("l1_e4_we", mem_we1, 1'b0);
    tick(); #1;
    chk1 ("l1_e5_we",     mem_we1,     1'b1);
    chk32("l1_e5_addr",   mem_addr1,   32'h44);
    chk32("l1_e5_wdata",  mem_wdata1,  32'h000055AA);
    chk1 ("l1_e5_enable", cpu_enable1, 1'b1);
    tick(); cpu_req1 = 1'b0; cpu_we1 = 1'b0; #1;
    chk1 ("l1_e6_we",     mem_we1,     1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
